multi_servo_controller: RTL and testbench

//   N-channel servo PWM engine, next generation of the single-servo arm controller.

---
 rtl/multi_servo_controller.sv | 110 +++++++++++
 tb/tb_multi_servo_controller.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_servo_controller.sv
// N-channel frame-aligned servo PWM engine with per-channel saturating position registers.
// Optional SOFT_HOME_EN adds home_req, which glides every channel toward CENTER_W.
module multi_servo_controller #(
    parameter int CHANNELS   = 4,
    parameter int PERIOD_CYC = 2_000_000,
    parameter int MIN_W      = 50_000,
    parameter int MAX_W      = 250_000,
    parameter int CENTER_W   = 150_000,
    parameter int STEP_W     = 1_000,
    localparam int W         = $clog2(PERIOD_CYC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   cw_req,
    input  logic [CHANNELS-1:0]   ccw_req,
`ifdef SOFT_HOME_EN
    input  logic                  home_req,
`endif
    output logic [CHANNELS-1:0]   servo,
    output logic                  frame_tick,
    output logic [CHANNELS*W-1:0] pos
);

    localparam logic [W-1:0] LAST_CNT = W'(PERIOD_CYC - 1);
    localparam logic [W:0]   MIN_X    = (W+1)'(MIN_W);
    localparam logic [W:0]   MAX_X    = (W+1)'(MAX_W);
    localparam logic [W:0]   CENTER_X = (W+1)'(CENTER_W);
    localparam logic [W:0]   STEP_X   = (W+1)'(STEP_W);

    logic [W-1:0] cnt_reg;
    logic         frame_tick_reg;
    logic         update;

    assign update     = (cnt_reg == LAST_CNT);
    assign frame_tick = frame_tick_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg        <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            cnt_reg        <= update ? '0 : cnt_reg + W'(1);
            frame_tick_reg <= (cnt_reg == '0);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [W-1:0] pos_reg;
            logic [W-1:0] width_reg;
            logic [W-1:0] pos_next;
            logic [W-1:0] step_next;
            logic [W:0]   pos_ext;
            logic [W:0]   inc;
            logic [W:0]   dec;
            logic         servo_reg;

            // One extra bit so the +STEP sum and the -STEP borrow are both visible.
            assign pos_ext = {1'b0, pos_reg};
            assign inc     = pos_ext + STEP_X;
            assign dec     = pos_ext - STEP_X;

            always_comb begin
                step_next = pos_reg;
                if (cw_req[gi] && !ccw_req[gi]) begin
                    step_next = (inc > MAX_X) ? MAX_X[W-1:0] : inc[W-1:0];
                end else if (ccw_req[gi] && !cw_req[gi]) begin
                    step_next = (dec[W] || dec < MIN_X) ? MIN_X[W-1:0] : dec[W-1:0];
                end
            end

`ifdef SOFT_HOME_EN
            logic [W-1:0] home_next;

            always_comb begin
                home_next = pos_reg;
                if (pos_ext > CENTER_X) begin
                    home_next = (dec[W] || dec < CENTER_X) ? CENTER_X[W-1:0] : dec[W-1:0];
                end else if (pos_ext < CENTER_X) begin
                    home_next = (inc > CENTER_X) ? CENTER_X[W-1:0] : inc[W-1:0];
                end
            end

            assign pos_next = home_req ? home_next : step_next;
`else
            assign pos_next = step_next;
`endif

            // width_reg is the frame's latched copy; it only moves at the frame boundary.
            always_ff @(posedge clk) begin
                if (!rst) begin
                    pos_reg   <= CENTER_X[W-1:0];
                    width_reg <= CENTER_X[W-1:0];
                    servo_reg <= 1'b0;
                end else begin
                    if (update) begin
                        pos_reg   <= pos_next;
                        width_reg <= pos_next;
                    end
                    servo_reg <= (cnt_reg < width_reg);
                end
            end

            assign servo[gi]          = servo_reg;
            assign pos[gi*W +: W]     = pos_reg;
        end
    endgenerate

endmodule

// File: tb/tb_multi_servo_controller.sv
// Scoreboard bench for multi_servo_controller: expected widths are queued per frame and
// compared against measured servo high-time when the following frame_tick arrives.
module tb_multi_servo_controller;
    localparam int CH = 4;
    localparam int W  = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [CH-1:0]   cw_req = '0;
    logic [CH-1:0]   ccw_req = '0;
`ifdef SOFT_HOME_EN
    logic            home_req = 1'b0;
`endif
    logic [CH-1:0]   servo;
    logic            frame_tick;
    logic [CH*W-1:0] pos;

    int tests_run = 0;
    int tests_failed = 0;
    int model_pos[CH];
    int hi_cnt[CH];
    logic [CH*W-1:0] exp_q[$];

    multi_servo_controller #(
        .CHANNELS(CH), .PERIOD_CYC(1000), .MIN_W(100), .MAX_W(300),
        .CENTER_W(200), .STEP_W(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cw_req(cw_req),
        .ccw_req(ccw_req),
`ifdef SOFT_HOME_EN
        .home_req(home_req),
`endif
        .servo(servo),
        .frame_tick(frame_tick),
        .pos(pos)
    );

    always #5 clk = ~clk;

    // Measure each channel's high time per frame; pop the expectation queued at frame start.
    always @(negedge clk) begin
        if (frame_tick) begin
            if (exp_q.size() > 0) begin
                logic [CH*W-1:0] e;
                e = exp_q.pop_front();
                for (int i = 0; i < CH; i++) begin
                    tests_run++;
                    if (hi_cnt[i] !== int'(e[i*W +: W])) begin
                        tests_failed++;
                        $display("FAIL pulse_width ch%0d: measured %0d, expected %0d", i, hi_cnt[i], int'(e[i*W +: W]));
                    end
                end
            end
            for (int i = 0; i < CH; i++) hi_cnt[i] = int'(servo[i]);
        end else begin
            for (int i = 0; i < CH; i++) hi_cnt[i] += int'(servo[i]);
        end
    end

    function automatic logic [CH*W-1:0] pack_model();
        logic [CH*W-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i*W +: W] = W'(model_pos[i]);
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) model_pos[i] = 200;
    endtask

    task automatic model_step(input logic [CH-1:0] cw, input logic [CH-1:0] ccw, input logic home);
        for (int i = 0; i < CH; i++) begin
            if (home) begin
                if (model_pos[i] > 200) model_pos[i] = (model_pos[i] - 10 < 200) ? 200 : model_pos[i] - 10;
                else if (model_pos[i] < 200) model_pos[i] = (model_pos[i] + 10 > 200) ? 200 : model_pos[i] + 10;
            end else if (cw[i] && !ccw[i]) begin
                model_pos[i] = (model_pos[i] + 10 > 300) ? 300 : model_pos[i] + 10;
            end else if (ccw[i] && !cw[i]) begin
                model_pos[i] = (model_pos[i] - 10 < 100) ? 100 : model_pos[i] - 10;
            end
        end
    endtask

    // Bounded wait for the next frame_tick; n = negedges waited.
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 2100);
        if (!frame_tick) begin
            tests_run++;
            tests_failed++;
            $display("FAIL tick_timeout: no frame_tick after %0d cycles, expected within 1000", n);
        end
    endtask

    // Hold requests across one update point, then queue widths for the frame just started.
    task automatic run_frame(input logic [CH-1:0] cw, input logic [CH-1:0] ccw, input logic home, output int n);
        cw_req  = cw;
        ccw_req = ccw;
`ifdef SOFT_HOME_EN
        home_req = home;
`endif
        wait_tick(n);
        model_step(cw, ccw, home);
        #1;
        exp_q.push_back(pack_model());
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (servo !== 4'b0000) begin tests_failed++; $display("FAIL reset_servo: got %b, expected 0000", servo); end
        tests_run++;
        if (frame_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_tick: got %b, expected 0", frame_tick); end
        for (int i = 0; i < CH; i++) begin
            tests_run++;
            if (pos[i*W +: W] !== W'(200)) begin tests_failed++; $display("FAIL reset_pos ch%0d: got %0d, expected 200", i, pos[i*W +: W]); end
        end
        rst = 1'b1;
        wait_tick(n);
        tests_run++;
        if (n !== 1) begin tests_failed++; $display("FAIL first_tick: after %0d cycles, expected 1", n); end
        model_reset();
        #1;
        exp_q.push_back(pack_model());
        for (int f = 0; f < 2; f++) begin
            run_frame('0, '0, 1'b0, n);
            tests_run++;
            if (n !== 1000) begin tests_failed++; $display("FAIL tick_period: got %0d, expected 1000", n); end
            for (int i = 0; i < CH; i++) begin
                tests_run++;
                if (pos[i*W +: W] !== W'(200)) begin tests_failed++; $display("FAIL idle_pos ch%0d: got %0d, expected 200", i, pos[i*W +: W]); end
            end
        end
    endtask

    task automatic test_cw_step();
        int n;
        for (int k = 1; k <= 3; k++) begin
            run_frame(4'b0001, '0, 1'b0, n);
            tests_run++;
            if (pos[0 +: W] !== W'(200 + 10*k)) begin tests_failed++; $display("FAIL cw_step pos0: got %0d, expected %0d", pos[0 +: W], 200 + 10*k); end
            for (int i = 1; i < CH; i++) begin
                tests_run++;
                if (pos[i*W +: W] !== W'(200)) begin tests_failed++; $display("FAIL cw_step other ch%0d: got %0d, expected 200", i, pos[i*W +: W]); end
            end
        end
    endtask

    task automatic test_saturation();
        int n;
        for (int k = 0; k < 15; k++) begin
            run_frame(4'b0100, 4'b0010, 1'b0, n);
            for (int i = 0; i < CH; i++) begin
                tests_run++;
                if (pos[i*W +: W] !== W'(model_pos[i])) begin tests_failed++; $display("FAIL sat_track ch%0d frame %0d: got %0d, expected %0d", i, k, pos[i*W +: W], model_pos[i]); end
            end
        end
        tests_run++;
        if (pos[1*W +: W] !== W'(100)) begin tests_failed++; $display("FAIL sat_min pos1: got %0d, expected 100", pos[1*W +: W]); end
        tests_run++;
        if (pos[2*W +: W] !== W'(300)) begin tests_failed++; $display("FAIL sat_max pos2: got %0d, expected 300", pos[2*W +: W]); end
    endtask

    task automatic test_conflict_and_glitch();
        int n;
        for (int k = 0; k < 2; k++) begin
            run_frame(4'b1000, 4'b1000, 1'b0, n);
            tests_run++;
            if (pos[3*W +: W] !== W'(200)) begin tests_failed++; $display("FAIL both_req pos3: got %0d, expected 200", pos[3*W +: W]); end
        end
        cw_req = '0;
        ccw_req = '0;
        wait_tick(n);
        #1;
        exp_q.push_back(pack_model());
        repeat (498) @(negedge clk);
        cw_req[3] = 1'b1;
        @(negedge clk);
        cw_req[3] = 1'b0;
        wait_tick(n);
        tests_run++;
        if (pos[3*W +: W] !== W'(200)) begin tests_failed++; $display("FAIL mid_frame_glitch pos3: got %0d, expected 200", pos[3*W +: W]); end
        #1;
        exp_q.push_back(pack_model());
    endtask

    task automatic test_reset_mid_frame();
        int n;
        run_frame(4'b0001, '0, 1'b0, n);
        run_frame(4'b0001, '0, 1'b0, n);
        tests_run++;
        if (pos[0 +: W] !== W'(250)) begin tests_failed++; $display("FAIL pre_reset pos0: got %0d, expected 250", pos[0 +: W]); end
        cw_req = '0;
        wait_tick(n);
        repeat (398) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (servo !== 4'b0000) begin tests_failed++; $display("FAIL midreset_servo: got %b, expected 0000", servo); end
        tests_run++;
        if (pos[0 +: W] !== W'(200)) begin tests_failed++; $display("FAIL midreset_pos0: got %0d, expected 200", pos[0 +: W]); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_tick(n);
        tests_run++;
        if (n !== 1) begin tests_failed++; $display("FAIL restart_tick: after %0d cycles, expected 1", n); end
        model_reset();
        #1;
        exp_q.push_back(pack_model());
        run_frame('0, '0, 1'b0, n);
        tests_run++;
        if (n !== 1000) begin tests_failed++; $display("FAIL restart_period: got %0d, expected 1000", n); end
        for (int i = 0; i < CH; i++) begin
            tests_run++;
            if (pos[i*W +: W] !== W'(200)) begin tests_failed++; $display("FAIL post_reset_pos ch%0d: got %0d, expected 200", i, pos[i*W +: W]); end
        end
    endtask

`ifdef SOFT_HOME_EN
    task automatic test_home();
        int n;
        int exp0[5];
        int exp1[5];
        exp0 = '{230, 220, 210, 200, 200};
        exp1 = '{170, 180, 190, 200, 200};
        for (int k = 0; k < 4; k++) run_frame(4'b0001, 4'b0010, 1'b0, n);
        for (int k = 0; k < 5; k++) begin
            run_frame(4'b0001, 4'b0010, 1'b1, n);
            tests_run++;
            if (pos[0 +: W] !== W'(exp0[k])) begin tests_failed++; $display("FAIL home pos0 step %0d: got %0d, expected %0d", k, pos[0 +: W], exp0[k]); end
            tests_run++;
            if (pos[1*W +: W] !== W'(exp1[k])) begin tests_failed++; $display("FAIL home pos1 step %0d: got %0d, expected %0d", k, pos[1*W +: W], exp1[k]); end
        end
        home_req = 1'b0;
    endtask
`endif

    task automatic test_drain();
        int n;
        cw_req = '0;
        ccw_req = '0;
        wait_tick(n);
        #1;
        tests_run++;
        if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size()); end
    endtask

    initial begin
        for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
        model_reset();
        test_reset();
        test_cw_step();
        test_saturation();
        test_conflict_and_glitch();
        test_reset_mid_frame();
`ifdef SOFT_HOME_EN
        test_home();
`endif
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
